// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported word memory between fetch and data stages
//
// Ports:
//   clk, reset              falling-edge clock, asynchronous active-high reset
//   if_req/if_addr          fetch request (byte address), completed by if_ack
//   if_stall                if_req & ~if_ack, for the pipeline
//   dm_req/dm_we/dm_addr/   data request (byte address), completed by dm_ack
//   dm_wdata
//   rdata, err              response data and error flag, valid while an ack is high
//   busy                    arbiter is not idle
//   mem_req/mem_we/         memory strobe, write enable, word index and write data
//   mem_addr/mem_wdata
//   mem_rdata, mem_ready    memory read data and completion
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MAX_STREAK = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [15:0]       dm_addr,
    input  logic [15:0]       dm_wdata,
    output logic              dm_ack,
    output logic [15:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_dm_q, owner_dm_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                grant_dm;
    logic                grant_if;
    logic [15:0]         sel_addr;
    logic                unused_addr_bits;

    // Data has priority, except that a pending fetch wins once data has
    // taken MAX_STREAK grants in a row while the fetch was waiting.
    assign grant_dm = dm_req && !(streak_q == STREAK_MAX && if_req);
    assign grant_if = !grant_dm && if_req;
    assign sel_addr = grant_dm ? dm_addr : if_addr;

    // Byte-address bits above the word index are dropped, so addresses wrap.
    assign unused_addr_bits = ^sel_addr[15:ADDR_W+1];

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_dm_q <= 1'b0;
            streak_q   <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    streak_d = '0;
                end
                if (grant_dm || grant_if) begin
                    owner_dm_d = grant_dm;
                    addr_d     = sel_addr[ADDR_W:1];
                    we_d       = grant_dm && dm_we;
                    wdata_d    = grant_dm ? dm_wdata : 16'h0000;
                    if (grant_if) begin
                        streak_d = '0;
                    end else if (if_req && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                    if (sel_addr[0]) begin
                        // Misaligned: answer with an error without touching memory.
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                    end else begin
                        state_d = ST_BUSY;
                        tmo_d   = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // TIMEOUT busy cycles have passed without completion.
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 16'h0000;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = (state_q == ST_BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == ST_RESP) && !owner_dm_q;
    assign dm_ack    = (state_q == ST_RESP) && owner_dm_q;
    assign if_stall  = if_req && !if_ack;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule
